// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory wait freezes,
// plus a saturating count of cycles lost to stalls and flushes.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rt,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        Branch_Taken,
    input  logic        MEM_Req,
    input  logic        Mem_Ready,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        Pipe_Freeze,
    output logic [1:0]  State,
    output logic [15:0] Stall_Count
);

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StFlush    = 2'b01,
        StMemWait  = 2'b10,
        StIllegal  = 2'b11
    } state_e;

    // A branch taken in RUN flushes once combinationally, so FLUSH covers the remainder.
    localparam logic [1:0] FlushLoadMem = 2'(FLUSH_CYCLES);
    localparam logic [1:0] FlushLoadRun = 2'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        pending_q, pending_d;
    logic [15:0] stall_cnt_q;

    logic load_use;
    logic mem_wait;
    logic stall_event;

    assign load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
    assign mem_wait = MEM_Req && !Mem_Ready;

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        state_d      = StRun;
        flush_cnt_d  = flush_cnt_q;
        pending_d    = pending_q;

        case (state_q)
            StRun: begin
                if (mem_wait) begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Freeze = 1'b1;
                    state_d     = StMemWait;
                end else if (Branch_Taken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    flush_cnt_d = FlushLoadRun;
                    state_d     = (FlushLoadRun != 2'd0) ? StFlush : StRun;
                end else if (load_use) begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end
            end
            StFlush: begin
                // Branch_Taken is ignored here: the flushed slots hold only wrong-path work.
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
                flush_cnt_d = (flush_cnt_q != 2'd0) ? flush_cnt_q - 2'd1 : 2'd0;
                state_d     = (flush_cnt_q > 2'd1) ? StFlush : StRun;
            end
            StMemWait: begin
                if (Branch_Taken) begin
                    pending_d = 1'b1;
                end
                if (!Mem_Ready) begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Freeze = 1'b1;
                    state_d     = StMemWait;
                end else if (pending_q || Branch_Taken) begin
                    flush_cnt_d = FlushLoadMem;
                    pending_d   = 1'b0;
                    state_d     = StFlush;
                end
            end
            default: state_d = StRun;
        endcase

        if (rst) begin
            PC_Write     = 1'b1;
            IF_ID_Write  = 1'b1;
            ID_EX_Bubble = 1'b0;
            IF_ID_Flush  = 1'b0;
            ID_EX_Flush  = 1'b0;
            Pipe_Freeze  = 1'b0;
        end
    end

    assign stall_event = !PC_Write || IF_ID_Flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= 2'd0;
            pending_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pending_q   <= pending_d;
            if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign State       = state_q;
    assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with FLUSH_CYCLES=2.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        Branch_Taken;
    logic        MEM_Req;
    logic        Mem_Ready;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        ID_EX_Bubble;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        Pipe_Freeze;
    logic [1:0]  State;
    logic [15:0] Stall_Count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze}
    logic [5:0] ctrl;
    assign ctrl = {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze};

    localparam logic [5:0] RunDef  = 6'b110000;
    localparam logic [5:0] LoadUse = 6'b001000;
    localparam logic [5:0] Flush   = 6'b110110;
    localparam logic [5:0] Freeze  = 6'b000001;

    localparam logic [1:0] SRun  = 2'b00;
    localparam logic [1:0] SFl   = 2'b01;
    localparam logic [1:0] SMw   = 2'b10;

    hazard_controller #(.FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_rt     (ID_EX_rt),
        .IF_ID_rs     (IF_ID_rs),
        .IF_ID_rt     (IF_ID_rt),
        .Branch_Taken (Branch_Taken),
        .MEM_Req      (MEM_Req),
        .Mem_Ready    (Mem_Ready),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .ID_EX_Bubble (ID_EX_Bubble),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .Pipe_Freeze  (Pipe_Freeze),
        .State        (State),
        .Stall_Count  (Stall_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check combinational controls and current state, then advance one clock.
    task automatic step(input string tag, input logic [5:0] exp_ctrl, input logic [1:0] exp_state);
        #1;
        chk({tag, "_ctrl"}, 16'(ctrl), 16'(exp_ctrl));
        chk({tag, "_state"}, 16'(State), 16'(exp_state));
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(input string tag, input logic [15:0] exp);
        chk({tag, "_cnt"}, Stall_Count, exp);
    endtask

    task automatic clear_inputs();
        ID_EX_MemRead = 1'b0;
        ID_EX_rt      = 5'd0;
        IF_ID_rs      = 5'd0;
        IF_ID_rt      = 5'd0;
        Branch_Taken  = 1'b0;
        MEM_Req       = 1'b0;
        Mem_Ready     = 1'b0;
    endtask

    initial begin
        clear_inputs();
        // Hazards presented during reset must not leak to the outputs.
        rst = 1'b1;
        MEM_Req = 1'b1; Branch_Taken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
        @(posedge clk);
        #1;
        step("rst_hold", RunDef, SRun);
        cnt("rst_hold", 16'd0);

        rst = 1'b0;
        clear_inputs();
        step("idle", RunDef, SRun);
        cnt("idle", 16'd0);

        // Load-use on rs
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
        step("lu_rs", LoadUse, SRun);
        cnt("lu_rs", 16'd1);
        clear_inputs();
        step("lu_after", RunDef, SRun);
        cnt("lu_after", 16'd1);

        // Load-use on rt
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd7; IF_ID_rt = 5'd7; IF_ID_rs = 5'd3;
        step("lu_rt", LoadUse, SRun);
        cnt("lu_rt", 16'd2);

        // Register 0 never stalls
        ID_EX_rt = 5'd0; IF_ID_rt = 5'd0; IF_ID_rs = 5'd0;
        step("lu_r0", RunDef, SRun);
        cnt("lu_r0", 16'd2);

        ID_EX_rt = 5'd5; IF_ID_rs = 5'd6; IF_ID_rt = 5'd7;
        step("lu_nomatch", RunDef, SRun);
        ID_EX_MemRead = 1'b0; IF_ID_rs = 5'd5;
        step("lu_noload", RunDef, SRun);
        cnt("lu_noload", 16'd2);

        // Taken branch: two flush cycles, Branch_Taken held high is ignored in FLUSH
        clear_inputs();
        Branch_Taken = 1'b1;
        step("br0", Flush, SRun);
        cnt("br0", 16'd3);
        step("br1", Flush, SFl);
        cnt("br1", 16'd4);
        Branch_Taken = 1'b0;
        step("br_done", RunDef, SRun);
        cnt("br_done", 16'd4);

        // Memory wait 3 cycles with branch in cycle 2, then FLUSH_CYCLES flushes
        MEM_Req = 1'b1; Mem_Ready = 1'b0;
        step("mw0", Freeze, SRun);
        cnt("mw0", 16'd5);
        Branch_Taken = 1'b1;
        step("mw1", Freeze, SMw);
        cnt("mw1", 16'd6);
        Branch_Taken = 1'b0;
        step("mw2", Freeze, SMw);
        cnt("mw2", 16'd7);
        Mem_Ready = 1'b1;
        step("mw_rel", RunDef, SMw);
        cnt("mw_rel", 16'd7);
        MEM_Req = 1'b0; Mem_Ready = 1'b0;
        step("mfl0", Flush, SFl);
        cnt("mfl0", 16'd8);
        step("mfl1", Flush, SFl);
        cnt("mfl1", 16'd9);
        step("mfl_done", RunDef, SRun);
        cnt("mfl_done", 16'd9);

        // Memory wait outranks branch and load-use
        MEM_Req = 1'b1; Branch_Taken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
        step("combo", Freeze, SRun);
        cnt("combo", 16'd10);

        // Reset mid-MEM_WAIT with a branch pending
        rst = 1'b1;
        step("rst_mw", RunDef, SMw);
        cnt("rst_mw", 16'd0);
        rst = 1'b0;
        clear_inputs();
        step("post_rst_mw", RunDef, SRun);
        cnt("post_rst_mw", 16'd0);

        // Pending flag must be gone: release returns to RUN, not FLUSH
        MEM_Req = 1'b1;
        step("pend0", Freeze, SRun);
        cnt("pend0", 16'd1);
        Mem_Ready = 1'b1;
        step("pend_rel", RunDef, SMw);
        clear_inputs();
        step("pend_clr", RunDef, SRun);

        // Reset mid-FLUSH
        Branch_Taken = 1'b1;
        step("fr0", Flush, SRun);
        cnt("fr0", 16'd2);
        Branch_Taken = 1'b0;
        rst = 1'b1;
        step("rst_fl", RunDef, SFl);
        cnt("rst_fl", 16'd0);
        rst = 1'b0;
        step("post_rst_fl", RunDef, SRun);
        step("post_rst_fl2", RunDef, SRun);
        cnt("post_rst_fl2", 16'd0);

        // Saturation over 65540 frozen cycles
        MEM_Req = 1'b1; Mem_Ready = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        cnt("sat", 16'hFFFF);
        chk("sat_state", 16'(State), 16'(SMw));
        chk("sat_ctrl", 16'(ctrl), 16'(Freeze));
        @(posedge clk);
        #1;
        cnt("sat_hold", 16'hFFFF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cnt("sat_rst", 16'd0);
        chk("sat_rst_state", 16'(State), 16'(SRun));
        chk("sat_rst_ctrl", 16'(ctrl), 16'(RunDef));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, meaning: cycles of IF_ID/ID_EX flush per taken branch (legal 1..3).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-005 ID_EX_rt  input  5  load destination register in EX.
REQ-006 IF_ID_rs, IF_ID_rt  input  5 each  source registers of instruction in ID.
REQ-007 Branch_Taken  input  1  branch resolved taken this cycle.
REQ-008 MEM_Req  input  1  EX_MEM holds a data-memory access.
REQ-009 Mem_Ready  input  1  data memory completes access this cycle.
REQ-010 PC_Write, IF_ID_Write  output  1 each  enables for PC and IF_ID.
REQ-011 ID_EX_Bubble  output  1  load zeros (NOP) into ID_EX.
REQ-012 IF_ID_Flush, ID_EX_Flush  output  1 each  clear the register to NOP.
REQ-013 Pipe_Freeze  output  1  hold ID_EX, EX_MEM, MEM_WB.
REQ-014 State  output  2  current FSM state.
REQ-015 Stall_Count  output  16  saturating count of lost cycles.

Function
REQ-016 States SHALL be RUN=2'b00, FLUSH=2'b01, MEM_WAIT=2'b10; 2'b11 SHALL return to RUN next cycle with all outputs at RUN defaults.
REQ-017 Outputs are combinational from State, the flush counter and current inputs; no extra latency.
REQ-018 RUN defaults: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
REQ-019 Priority in RUN: memory wait > taken branch > load-use hazard.
REQ-020 Memory wait: MEM_Req=1 and Mem_Ready=0 -> PC_Write=0, IF_ID_Write=0, Pipe_Freeze=1 this cycle; next state MEM_WAIT.
REQ-021 MEM_WAIT: hold freeze outputs while Mem_Ready=0; on Mem_Ready=1 release freeze that cycle (RUN defaults), next state RUN, or FLUSH if a branch is pending.
REQ-022 Branch_Taken=1 while in MEM_WAIT SHALL set a pending flag; pending flag clears on entry to FLUSH.
REQ-023 Taken branch in RUN: IF_ID_Flush=1, ID_EX_Flush=1 that cycle; flush counter loaded with FLUSH_CYCLES-1; next state FLUSH if counter load >0, else RUN.
REQ-024 FLUSH: flush outputs asserted, counter decrements each cycle, exit to RUN after counter reaches 0; Branch_Taken in FLUSH SHALL be ignored.
REQ-025 Entry to FLUSH from MEM_WAIT SHALL load counter with FLUSH_CYCLES and flush for FLUSH_CYCLES cycles.
REQ-026 Load-use: ID_EX_MemRead=1, ID_EX_rt!=0, and ID_EX_rt equals IF_ID_rs or IF_ID_rt -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly that cycle; state stays RUN.
REQ-027 Register 0 SHALL never cause a load-use stall.
REQ-028 Stall_Count SHALL increment by 1 on every cycle with PC_Write=0 or IF_ID_Flush=1, saturating at 16'hFFFF.

Reset
REQ-029 rst=1 at a clock edge SHALL force State=RUN, flush counter=0, pending flag=0, Stall_Count=0, overriding any state including mid-MEM_WAIT or mid-FLUSH.
REQ-030 While rst is asserted, outputs SHALL show RUN defaults.

Verification
REQ-031 Load-use: ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 for 1 cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 one cycle; Stall_Count 0->1.
REQ-032 rt=0 load: ID_EX_MemRead=1, ID_EX_rt=0, IF_ID_rt=0 -> no stall, Stall_Count unchanged.
REQ-033 FLUSH_CYCLES=2, Branch_Taken pulse -> flush outputs high exactly 2 cycles, State RUN->FLUSH->RUN, Stall_Count +2.
REQ-034 MEM_Req=1, Mem_Ready=0 for 3 cycles with Branch_Taken=1 in cycle 2, then Mem_Ready=1 -> Pipe_Freeze high 3 cycles, then FLUSH_CYCLES flush cycles, then RUN.
REQ-035 Simultaneous memory wait, branch and load-use in RUN -> only freeze outputs asserted; State=MEM_WAIT.
REQ-036 rst pulse mid-FLUSH and mid-MEM_WAIT; also 65540 forced stall cycles -> State=RUN, Stall_Count=0 after reset; counter holds 16'hFFFF at saturation.
